// File: rtl/fir_pkg.sv
// Shared types and sizing for the FIR datapath.
// The ingress stage and the FIR core both import this package.
package fir_pkg;

    localparam int unsigned SAMPLE_W      = 8;
    localparam int unsigned INGRESS_DEPTH = 4;

    typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/fir_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, followed by a rising-edge detector.
// o_edge is a single-cycle pulse and is low out of reset.
module fir_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/fir_sample_ingress.sv
// Strobe-qualified sample capture into a small FWFT FIFO feeding the FIR core.
// Reports fill level and a sticky overflow flag for dropped samples.
module fir_sample_ingress
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W      = SAMPLE_W,
    parameter int unsigned DEPTH       = INGRESS_DEPTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [DATA_W-1:0]        din,
    input  logic                     strobe,
    input  logic                     clr_ovf,
    output logic                     s_valid,
    output logic [DATA_W-1:0]        s_data,
    input  logic                     s_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    logic              w_edge;
    logic              w_push_req;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf_set;
    logic [LvlW-1:0]   w_level_nxt;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]   r_wptr;
    logic [PtrW-1:0]   r_rptr;
    logic [LvlW-1:0]   r_level;
    logic              r_ovf;

    fir_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (strobe),
        .o_edge  (w_edge)
    );

    assign empty    = (r_level == '0);
    assign full     = (r_level == LvlW'(DEPTH));
    assign s_valid  = ~empty;
    assign s_data   = r_mem[r_rptr];
    assign level    = r_level;
    assign overflow = r_ovf;

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_push_req = w_edge & ena;
    assign w_pop      = s_valid & s_ready;
    assign w_push     = w_push_req & (~full | w_pop);
    assign w_ovf_set  = w_push_req & full & ~w_pop;

    always_comb begin
        w_level_nxt = r_level;
        unique case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LvlW'(1);
            2'b01:   w_level_nxt = r_level - LvlW'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PtrW'(1);
            end
            r_level <= w_level_nxt;
        end
    end

    // A drop on the same edge as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_sample_ingress.sv
// Directed bench for fir_sample_ingress with hand-computed expectations.
// Inputs change 1ns after a rising edge; outputs are checked at the same point.
module tb_fir_sample_ingress;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] din;
    logic       strobe;
    logic       clr_ovf;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic [2:0] level;
    logic       full;
    logic       empty;
    logic       overflow;

    int checks;
    int failures;

    fir_sample_ingress #(
        .DATA_W      (8),
        .DEPTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .din      (din),
        .strobe   (strobe),
        .clr_ovf  (clr_ovf),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .level    (level),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Strobe high 4 cycles, low 4 cycles; the push lands on the third edge.
    task automatic push(input logic [7:0] d);
        din    = d;
        strobe = 1'b1;
        step(4);
        strobe = 1'b0;
        step(4);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, 32'(s_valid), 32'd1);
        chk({tag, "_data"}, 32'(s_data), 32'(exp));
        s_ready = 1'b1;
        step(1);
        s_ready = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        ena      = 1'b0;
        din      = 8'h00;
        strobe   = 1'b0;
        clr_ovf  = 1'b0;
        s_ready  = 1'b0;

        // Reset state
        step(2);
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_data", 32'(s_data), 32'h00);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        step(1);

        // Single sample: latency and one push per long strobe
        ena    = 1'b1;
        din    = 8'h5A;
        strobe = 1'b1;
        step(1);
        chk("lat_e1_valid", 32'(s_valid), 32'd0);
        step(1);
        chk("lat_e2_valid", 32'(s_valid), 32'd0);
        step(1);
        chk("lat_e3_valid", 32'(s_valid), 32'd1);
        chk("lat_e3_data", 32'(s_data), 32'h5A);
        chk("lat_e3_level", 32'(level), 32'd1);
        step(1);
        strobe = 1'b0;
        step(4);
        chk("single_level", 32'(level), 32'd1);
        pop_expect("single_pop", 8'h5A);
        chk("single_empty", 32'(empty), 32'd1);

        // Backpressure ordering
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        chk("bp_full", 32'(full), 32'd1);
        chk("bp_level", 32'(level), 32'd4);
        chk("bp_head", 32'(s_data), 32'h11);
        step(3);
        chk("bp_head_held", 32'(s_data), 32'h11);
        s_ready = 1'b1;
        chk("bp_d0", 32'(s_data), 32'h11);
        step(1);
        chk("bp_d1", 32'(s_data), 32'h22);
        step(1);
        chk("bp_d2", 32'(s_data), 32'h33);
        step(1);
        chk("bp_d3", 32'(s_data), 32'h44);
        step(1);
        s_ready = 1'b0;
        chk("bp_empty", 32'(empty), 32'd1);
        chk("bp_valid", 32'(s_valid), 32'd0);

        // Overflow, clear, and clear colliding with a new drop
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        push(8'hA4);
        push(8'h99);
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_head", 32'(s_data), 32'hA1);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);
        din    = 8'h98;
        strobe = 1'b1;
        step(2);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        chk("ovf_clr_vs_set", 32'(overflow), 32'd1);
        step(1);
        strobe = 1'b0;
        step(4);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        chk("ovf_clr2", 32'(overflow), 32'd0);
        pop_expect("ovf_p0", 8'hA1);
        pop_expect("ovf_p1", 8'hA2);
        pop_expect("ovf_p2", 8'hA3);
        pop_expect("ovf_p3", 8'hA4);
        chk("ovf_empty", 32'(empty), 32'd1);

        // Full with push and pop on the same edge
        push(8'hB1);
        push(8'hB2);
        push(8'hB3);
        push(8'hB4);
        din    = 8'h55;
        strobe = 1'b1;
        step(2);
        s_ready = 1'b1;
        step(1);
        s_ready = 1'b0;
        chk("pp_level", 32'(level), 32'd4);
        chk("pp_ovf", 32'(overflow), 32'd0);
        chk("pp_head", 32'(s_data), 32'hB2);
        step(1);
        strobe = 1'b0;
        step(4);
        pop_expect("pp_p0", 8'hB2);
        pop_expect("pp_p1", 8'hB3);
        pop_expect("pp_p2", 8'hB4);
        pop_expect("pp_p3", 8'h55);
        chk("pp_empty", 32'(empty), 32'd1);

        // Enable gating, then pointer wrap
        ena = 1'b0;
        push(8'h77);
        chk("ena_level", 32'(level), 32'd0);
        chk("ena_ovf", 32'(overflow), 32'd0);
        ena = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(8'(i));
            pop_expect($sformatf("wrap%0d", i), 8'(i));
        end
        chk("wrap_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-stream, strobe held high across release
        push(8'hC1);
        push(8'hC2);
        push(8'hC3);
        chk("mid_level", 32'(level), 32'd3);
        din    = 8'hE7;
        strobe = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(s_valid), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_data", 32'(s_data), 32'h00);
        step(2);
        rst_n = 1'b1;
        step(5);
        chk("rel_level", 32'(level), 32'd1);
        chk("rel_data", 32'(s_data), 32'hE7);
        step(4);
        chk("rel_level_once", 32'(level), 32'd1);
        strobe = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_sample_ingress.md
Name: fir_sample_ingress

Overview:
- Upstream stage of the FIR core; sits between the tile's 8-bit input pins and the filter's sample input.
- Synchronises an asynchronous sample strobe and detects its rising edge.
- Captures the 8-bit sample on that edge and buffers it in a small FWFT FIFO.
- Presents samples to the FIR core on a valid/ready handshake; reports fill level and a sticky overflow flag.

Parameters:
- DATA_W, 8, sample width in bits.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2, synchroniser flops on the strobe; at least 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  tile enable; when low, no pushes occur.
- din  in  DATA_W  sample bus from the input pins; async, quasi-static.
- strobe  in  1  asynchronous sample strobe; a rising edge means "din holds a new sample".
- clr_ovf  in  1  synchronous clear for the overflow flag.
- s_valid  out  1  head sample is available.
- s_data  out  DATA_W  head sample.
- s_ready  in  1  FIR core accepts the head sample.
- level  out  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- overflow  out  1  sticky; a sample was dropped.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: all sync flops, pointers and level are 0; overflow = 0; s_valid = 0; s_data = 0; empty = 1; full = 0.
- Synchroniser: strobe passes through SYNC_STAGES flops, then one "prev" flop.
  - edge = sync_out AND NOT prev (combinational).
- Push:
  - Condition: edge is high at a rising clk and ena = 1.
  - Action: din is written at the write pointer on that clk edge.
  - Latency: with SYNC_STAGES = 2 and strobe rising before clk edge k, the push occurs at edge k+2. s_valid is high after edge k+2 when the FIFO was previously empty.
  - din must be stable from the strobe rise through the push edge. The block does not check this.
- Strobe pulse rules:
  - One push per strobe rising edge, regardless of how long strobe stays high.
  - Strobe must stay low for at least SYNC_STAGES+1 cycles between edges; narrower gaps may merge.
- Pop:
  - Condition: s_valid and s_ready both high at a rising clk.
  - Action: the read pointer advances.
  - s_data is the FWFT head, driven from the storage array at the read pointer.
  - s_data is held stable while s_valid = 1 and s_ready = 0.
  - When empty, s_data holds the last-read slot and is don't-care.
- s_valid = NOT empty. It must not depend combinationally on s_ready.
- Pointers: log2(DEPTH) bits, natural wrap. level is a separate counter.
  - +1 on push only, -1 on pop only, unchanged on push and pop together.
- Boundary conditions:
  - Full with push and pop in the same cycle: both are accepted; level stays DEPTH; no overflow.
  - Full with push and no pop: sample dropped; storage and pointers unchanged; overflow set on that edge.
  - Empty with push: s_valid rises the next cycle. No pop is possible in the same cycle because s_valid was low.
  - ena = 0: edges are consumed (prev still updates) but not pushed; pops continue; overflow is not set.
  - clr_ovf = 1 clears overflow on the next edge. A simultaneous overflow event wins, so overflow stays 1.
  - Reset mid-operation: contents are discarded and all outputs return to reset values immediately (asynchronous).
  - Strobe held high across reset release: the sync chain rises from 0, which produces exactly one push, provided ena = 1.

Decomposition:
- Package fir_pkg holds:
  - SAMPLE_W = 8.
  - INGRESS_DEPTH = 4.
  - typedef sample_t (logic [SAMPLE_W-1:0]), shared with the FIR core.
- One sub-module: fir_sync_edge, a parameterised synchroniser plus rising-edge detector. It outputs a single-cycle edge pulse and resets to 0.
- FIFO storage and pointer logic stay inline in fir_sample_ingress.

Test Plan:
- Reset then single sample: ena = 1, din = 0x5A, strobe pulses high for 4 cycles → s_valid rises 3 edges after strobe; s_data = 0x5A; level = 1; exactly one entry pushed.
- Backpressure ordering: s_ready = 0, push 0x11, 0x22, 0x33, 0x44 → full = 1, level = 4, s_data = 0x11 held. Then s_ready = 1 → pops in order 0x11, 0x22, 0x33, 0x44; then empty = 1.
- Overflow: while full with s_ready = 0, push 0x99 → level stays 4, overflow = 1, 0x99 never appears. clr_ovf pulse → overflow = 0.
- Full with simultaneous push and pop: s_ready = 1 on the push edge → level stays 4, overflow = 0, and 0x55 is output after the existing four entries.
- ena gating and wrap: ena = 0, strobe edge → level unchanged. Then ena = 1, with 10 push/pop pairs, data 0x00..0x09 → pointers wrap and outputs match in order.
- Reset mid-stream: level = 3, assert rst_n = 0 asynchronously → s_valid, level, overflow = 0 immediately. Strobe held high on release → one push.
